matrix_inv_check: RTL and testbench
===================================

Name: matrix_inv_check

Overview:
- Downstream consumer of the 2x2 matrix inverter.
- Takes the original matrix (a,b,c,d) together with the inverter's result (a_inv..d_inv, error) and computes P = M x M_inv serially on one shared signed multiplier.
- Checks P against the identity within a fixed-point tolerance, then reports the product, a pass flag and the worst-case error over a valid/ready handshake.
- Serves as the self-check stage after inversion, both on the board and in regression.

Parameters:
- W, 16: data width of every matrix element (signed two's complement).
- FRAC, 8: fractional bits; 1.0 = 1<<FRAC (Q8.8 at default).
- TOL, 2: maximum allowed |P - I| per element, in LSBs.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  inputs below are valid
- in_ready  out  1  block can accept a new set
- a, b, c, d  in  W each  original matrix [[a,b],[c,d]]
- a_inv, b_inv, c_inv, d_inv  in  W each  inverse from the inverter
- inv_error  in  1  inverter flagged a singular matrix
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- p00, p01, p10, p11  out  W each  saturated elements of M x M_inv
- pass  out  1  all |P - I| <= TOL and inv_error=0
- singular  out  1  captured inv_error
- max_err  out  W  max |P - I| over the 4 elements, unsigned, saturated to 2^W-1
- fail_cnt  out  16  failed-check counter (optional feature)

Behaviour:
- Clock/reset: one clock `clk`; `reset` is synchronous and active-high. Reset takes priority over everything, including mid-operation: state goes to IDLE and the partial accumulation is discarded.
- Reset values: in_ready=1, out_valid=0, p00..p11=0, pass=0, singular=0, max_err=0, fail_cnt=0.
- FSM states: IDLE, MUL, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T), register all 8 elements and inv_error; in_ready drops.
  - If inv_error=1, go to DONE with p*=0, max_err=all-ones, pass=0, singular=1, so out_valid rises at T+1.
  - Otherwise go to MUL.
- MUL (8 cycles, T+1..T+8):
  - idx counts 0..7 and performs one W x W signed multiply per cycle, 2W-bit result.
  - Products accumulate into a (2W+1)-bit signed accumulator.
  - Order: a*a_inv, b*c_inv -> p00; a*b_inv, b*d_inv -> p01; c*a_inv, d*c_inv -> p10; c*b_inv, d*d_inv -> p11.
  - On each odd idx, the sum is arithmetically shifted right by FRAC (truncation toward -inf), saturated to [-2^(W-1), 2^(W-1)-1], and written to the p register. The accumulator then clears.
- CMP (T+9):
  - Error terms: e00 = |p00 - (1<<FRAC)|, e11 = |p11 - (1<<FRAC)|, e01 = |p01|, e10 = |p10|.
  - Each error is computed in W+1 bits, then saturated to W unsigned bits.
  - max_err = maximum of the four; pass = (max_err <= TOL); singular=0.
  - Go to DONE.
- DONE:
  - out_valid=1 from T+10 (normal path) or T+1 (singular path).
  - All outputs are held stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE; in_ready returns the next cycle. No new capture happens in the handshake cycle.
- Throughput: one result per 11 cycles minimum (normal path).
- in_valid while busy is ignored; the upstream block must hold its data until in_ready.
- Outputs p*, pass, max_err keep their last values after the handshake, until the next result is written.

Optional Feature:
- Macro: MATRIX_INV_CHECK_FAILCNT_EN.
- Defined: fail_cnt increments by 1 on each result handshake with pass=0, saturating at 16'hFFFF. It is cleared only by reset.
- Not defined: fail_cnt is constant 0 and no counter logic is built. Port list is unchanged.

Test Plan:
- Identity: a=d=0x0100, b=c=0, inverse identical, inv_error=0 -> at T+10 p00=p11=0x0100, p01=p10=0, max_err=0, pass=1, singular=0.
- Diagonal: a=0x0200, d=0x0400, a_inv=0x0080, d_inv=0x0040, others 0 -> p00=p11=0x0100, pass=1.
- Tolerance: a=0x0300, a_inv=0x0055, d=d_inv=0x0100 -> p00=0x00FF, max_err=1, pass=1 with TOL=2; rerun with TOL=0 -> pass=0, and fail_cnt=1 when the feature is enabled.
- Singular/saturation:
  - inv_error=1 -> out_valid at T+1, singular=1, pass=0, p*=0, max_err=0xFFFF.
  - a=a_inv=0x7FFF, others 0 -> p00=0x7FFF (saturated), pass=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, extra in_valid pulses ignored; out_ready=1 -> out_valid falls, in_ready=1 the next cycle.
- Reset mid-MUL: assert reset at T+4 for one cycle -> IDLE next cycle with all outputs at reset values; a new identity request then completes in 10 cycles with pass=1.

Source files
------------

// File: rtl/matrix_inv_check.sv
// rtl/matrix_inv_check.sv - serial M x M_inv identity check for the 2x2 inverter
// Optional failed-check counter: define MATRIX_INV_CHECK_FAILCNT_EN.
module matrix_inv_check #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int TOL  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] a_inv,
    input  logic [W-1:0] b_inv,
    input  logic [W-1:0] c_inv,
    input  logic [W-1:0] d_inv,
    input  logic         inv_error,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] p00,
    output logic [W-1:0] p01,
    output logic [W-1:0] p10,
    output logic [W-1:0] p11,
    output logic         pass,
    output logic         singular,
    output logic [W-1:0] max_err,
    output logic [15:0]  fail_cnt
);
    typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;

    localparam logic [W-1:0]       ONE     = W'(1 << FRAC);
    localparam logic [W-1:0]       TOL_W   = W'(TOL);
    localparam logic signed [2*W:0] SAT_MAX = (2*W+1)'((1 << (W-1)) - 1);
    localparam logic signed [2*W:0] SAT_MIN = -SAT_MAX - 1;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic signed [2*W:0]    acc_q, acc_d;
    logic [7:0][W-1:0]      m_q, m_d;
    logic [3:0][W-1:0]      p_q, p_d;
    logic [W-1:0]           max_err_q, max_err_d;
    logic                   pass_q, pass_d;
    logic                   singular_q, singular_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [W-1:0]           op_l, op_r, sat_p, err_max;
    logic signed [2*W-1:0]  prod;
    logic signed [2*W:0]    sum, shifted;
    logic [3:0][W-1:0]      err;

    function automatic logic [W-1:0] sat_abs(input logic [W-1:0] v, input logic [W-1:0] tgt);
        logic [W:0] diff, mag;
        diff = {v[W-1], v} - {tgt[W-1], tgt};
        mag  = diff[W] ? -diff : diff;
        return mag[W] ? '1 : mag[W-1:0];
    endfunction

    // m_q holds a,b,c,d,a_inv,b_inv,c_inv,d_inv; idx[2] picks the row, idx[1] the column, idx[0] the term
    always_comb begin
        op_l    = idx_q[0] ? (idx_q[2] ? m_q[3] : m_q[1]) : (idx_q[2] ? m_q[2] : m_q[0]);
        op_r    = idx_q[0] ? (idx_q[1] ? m_q[7] : m_q[6]) : (idx_q[1] ? m_q[5] : m_q[4]);
        prod    = $signed(op_l) * $signed(op_r);
        sum     = acc_q + {prod[2*W-1], prod};
        shifted = sum >>> FRAC;
        if (shifted > SAT_MAX)      sat_p = {1'b0, {(W-1){1'b1}}};
        else if (shifted < SAT_MIN) sat_p = {1'b1, {(W-1){1'b0}}};
        else                        sat_p = shifted[W-1:0];

        err[0]  = sat_abs(p_q[0], ONE);
        err[1]  = sat_abs(p_q[1], '0);
        err[2]  = sat_abs(p_q[2], '0);
        err[3]  = sat_abs(p_q[3], ONE);
        err_max = err[0];
        for (int i = 1; i < 4; i++)
            if (err[i] > err_max) err_max = err[i];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        m_d         = m_q;
        p_d         = p_q;
        max_err_d   = max_err_q;
        pass_d      = pass_q;
        singular_d  = singular_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    m_d        = {d_inv, c_inv, b_inv, a_inv, d, c, b, a};
                    in_ready_d = 1'b0;
                    idx_d      = '0;
                    acc_d      = '0;
                    if (inv_error) begin
                        p_d         = '0;
                        max_err_d   = '1;
                        pass_d      = 1'b0;
                        singular_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                idx_d = idx_q + 3'd1;
                if (idx_q[0]) begin
                    p_d[idx_q[2:1]] = sat_p;
                    acc_d           = '0;
                end else begin
                    acc_d = sum;
                end
                if (idx_q == 3'd7) state_d = CMP;
            end
            CMP: begin
                max_err_d   = err_max;
                pass_d      = (err_max <= TOL_W);
                singular_d  = 1'b0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            m_q         <= '0;
            p_q         <= '0;
            max_err_q   <= '0;
            pass_q      <= 1'b0;
            singular_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            m_q         <= m_d;
            p_q         <= p_d;
            max_err_q   <= max_err_d;
            pass_q      <= pass_d;
            singular_q  <= singular_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MATRIX_INV_CHECK_FAILCNT_EN
    logic [15:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (state_q == DONE && out_ready && !pass_q && fail_cnt_q != 16'hFFFF)
            fail_cnt_d = fail_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) fail_cnt_q <= '0;
        else       fail_cnt_q <= fail_cnt_d;
    end

    assign fail_cnt = fail_cnt_q;
`else
    assign fail_cnt = '0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign p00       = p_q[0];
    assign p01       = p_q[1];
    assign p10       = p_q[2];
    assign p11       = p_q[3];
    assign pass      = pass_q;
    assign singular  = singular_q;
    assign max_err   = max_err_q;
endmodule

// File: tb/tb_matrix_inv_check.sv
// tb/tb_matrix_inv_check.sv - directed bench for matrix_inv_check (TOL=2 and TOL=0 instances)
module tb_matrix_inv_check;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        inv_error = 1'b0;
    logic [15:0] a = '0, b = '0, c = '0, d = '0;
    logic [15:0] a_inv = '0, b_inv = '0, c_inv = '0, d_inv = '0;

    logic        in_ready, out_valid, pass, singular;
    logic [15:0] p00, p01, p10, p11, max_err, fail_cnt;
    logic        in_ready0, out_valid0, pass0, singular0;
    logic [15:0] q00, q01, q10, q11, max_err0, fail_cnt0;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] exp_p [4];
    logic [15:0] exp_max;
    logic        exp_pass, exp_pass0, exp_sing;
    int          exp_fail = 0, exp_fail0 = 0;

    always #5 clk = ~clk;

    matrix_inv_check #(.W(16), .FRAC(8), .TOL(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d),
        .a_inv(a_inv), .b_inv(b_inv), .c_inv(c_inv), .d_inv(d_inv),
        .inv_error(inv_error), .out_valid(out_valid), .out_ready(out_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .pass(pass), .singular(singular), .max_err(max_err), .fail_cnt(fail_cnt)
    );

    matrix_inv_check #(.W(16), .FRAC(8), .TOL(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .c(c), .d(d),
        .a_inv(a_inv), .b_inv(b_inv), .c_inv(c_inv), .d_inv(d_inv),
        .inv_error(inv_error), .out_valid(out_valid0), .out_ready(out_ready),
        .p00(q00), .p01(q01), .p10(q10), .p11(q11),
        .pass(pass0), .singular(singular0), .max_err(max_err0), .fail_cnt(fail_cnt0)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Plain-integer model: P = M * Minv / 256 (floor), clamped; errors against identity
    task automatic set_expect(input logic [15:0] va, vb, vc, vd, vai, vbi, vci, vdi, input logic vie);
        longint m [4];
        longint n [4];
        longint s, e, tgt, mx;
        m = '{sx(va), sx(vb), sx(vc), sx(vd)};
        n = '{sx(vai), sx(vbi), sx(vci), sx(vdi)};
        mx = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = m[2*i] * n[j] + m[2*i+1] * n[2+j];
                s = (s - (((s % 256) + 256) % 256)) / 256;
                if (s > 32767)  s = 32767;
                if (s < -32768) s = -32768;
                exp_p[2*i+j] = 16'(s);
                tgt = (i == j) ? 256 : 0;
                e = (s > tgt) ? s - tgt : tgt - s;
                if (e > 65535) e = 65535;
                if (e > mx) mx = e;
            end
        end
        if (vie) begin
            for (int k = 0; k < 4; k++) exp_p[k] = 16'h0000;
            mx = 65535;
        end
        exp_max   = 16'(mx);
        exp_sing  = vie;
        exp_pass  = !vie && (mx <= 2);
        exp_pass0 = !vie && (mx == 0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            check("p00", p00, exp_p[0]);
            check("p01", p01, exp_p[1]);
            check("p10", p10, exp_p[2]);
            check("p11", p11, exp_p[3]);
            check("max_err", max_err, exp_max);
            check("pass", pass, exp_pass);
            check("singular", singular, exp_sing);
            check("in_ready_busy", in_ready, 0);
            check("pass_tol0", pass0, exp_pass0);
            check("out_valid_tol0", out_valid0, 1);
            check("fail_cnt", fail_cnt, exp_fail);
            check("fail_cnt_tol0", fail_cnt0, exp_fail0);
        end
    end

    task automatic check_reset_vals();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_p00", p00, 0);
        check("rst_p01", p01, 0);
        check("rst_p10", p10, 0);
        check("rst_p11", p11, 0);
        check("rst_pass", pass, 0);
        check("rst_singular", singular, 0);
        check("rst_max_err", max_err, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_fail_cnt_tol0", fail_cnt0, 0);
    endtask

    task automatic run(input logic [15:0] va, vb, vc, vd, vai, vbi, vci, vdi,
                       input logic vie, input int hold);
        int lat;
        check("in_ready_idle", in_ready, 1);
        set_expect(va, vb, vc, vd, vai, vbi, vci, vdi, vie);
        a = va; b = vb; c = vc; d = vd;
        a_inv = vai; b_inv = vbi; c_inv = vci; d_inv = vdi;
        inv_error = vie;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, vie ? 1 : 10);
        for (int i = 0; i < hold; i++) begin
            in_valid  = (i == 1 || i == 3);
            a         = ~va;
            inv_error = ~vie;
            @(negedge clk);
        end
        in_valid = 1'b0;
        a = va;
        inv_error = vie;
        out_ready = 1'b1;
        @(posedge clk);
`ifdef MATRIX_INV_CHECK_FAILCNT_EN
        if (!exp_pass)  exp_fail++;
        if (!exp_pass0) exp_fail0++;
`endif
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("p00_held", p00, exp_p[0]);
        check("max_err_held", max_err, exp_max);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals();

        run(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, 0);
        check("lit_identity_p00", p00, 16'h0100);
        check("lit_identity_max", max_err, 16'h0000);
        check("lit_identity_pass", pass, 1);

        run(16'h0200, 16'h0000, 16'h0000, 16'h0400, 16'h0080, 16'h0000, 16'h0000, 16'h0040, 1'b0, 0);
        check("lit_diag_p11", p11, 16'h0100);

        run(16'h0300, 16'h0000, 16'h0000, 16'h0100, 16'h0055, 16'h0000, 16'h0000, 16'h0100, 1'b0, 0);
        check("lit_tol_p00", p00, 16'h00FF);
        check("lit_tol_max", max_err, 16'h0001);
        check("lit_tol_pass", pass, 1);
        check("lit_tol0_pass", pass0, 0);
`ifdef MATRIX_INV_CHECK_FAILCNT_EN
        check("lit_tol0_fail_cnt", fail_cnt0, 1);
`endif

        run(16'h1234, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 1'b1, 0);
        check("lit_sing_max", max_err, 16'hFFFF);
        check("lit_sing_flag", singular, 1);

        run(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0);
        check("lit_sat_p00", p00, 16'h7FFF);
        check("lit_sat_pass", pass, 0);

        run(16'h7FFF, 16'h0000, 16'h0000, 16'h0100, 16'h8000, 16'h0000, 16'h0000, 16'h0100, 1'b0, 0);
        check("lit_negsat_p00", p00, 16'h8000);
        check("lit_negsat_max", max_err, 16'h8100);

        run(16'hFFFF, 16'h0000, 16'h0000, 16'h0100, 16'h0001, 16'h0000, 16'h0000, 16'h0100, 1'b0, 0);
        check("lit_floor_p00", p00, 16'hFFFF);

        run(16'h0123, 16'hFE10, 16'h0042, 16'h0200, 16'h00E0, 16'h0011, 16'hFFF0, 16'h0080, 1'b0, 0);
        run(16'h0100, 16'hFF80, 16'h0000, 16'h0100, 16'h0100, 16'h0080, 16'h0000, 16'h0100, 1'b0, 5);

        a = 16'h0100; b = '0; c = '0; d = 16'h0100;
        a_inv = 16'h0100; b_inv = '0; c_inv = '0; d_inv = 16'h0100;
        inv_error = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_fail = 0;
        exp_fail0 = 0;
        check_reset_vals();
        run(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0, 0);
        check("lit_after_reset_pass", pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
